cart_irq_ctrl: RTL and testbench



---
 rtl/nileswan_pkg.sv | 26 ++
 rtl/irq_timer.sv | 68 ++++++
 rtl/cart_irq_ctrl.sv | 148 ++++++++++++++
 tb/tb_cart_irq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nileswan_pkg.sv
// Shared definitions for the nileswan cartridge extension registers.
//   - Register addresses of the interrupt controller block (0xE6-0xEA)
//   - Bit positions of the three interrupt sources in enable/status
//   - Timer state encoding used by irq_timer
package nileswan_pkg;

   localparam logic [7:0] IRQ_ENABLE      = 8'hE6;
   localparam logic [7:0] IRQ_STATUS      = 8'hE7;
   localparam logic [7:0] TIMER_RELOAD_LO = 8'hE8;
   localparam logic [7:0] TIMER_RELOAD_HI = 8'hE9;
   localparam logic [7:0] TIMER_CTRL      = 8'hEA;

   localparam int IRQ_W         = 3;
   localparam int IRQ_BIT_SPI   = 0;
   localparam int IRQ_BIT_TIMER = 1;
   localparam int IRQ_BIT_MCU   = 2;

   localparam int CTRL_BIT_RUN  = 0;
   localparam int CTRL_BIT_AUTO = 1;

   typedef enum logic {
      TMR_IDLE  = 1'b0,
      TMR_COUNT = 1'b1
   } timer_state_t;

endpackage

// File: rtl/irq_timer.sv
// Programmable interval timer for the cartridge interrupt controller.
//
// state     | meaning
// ----------+--------------------------------------------------------
// TMR_IDLE  | stopped, counter frozen
// TMR_COUNT | prescaler running, counter decrements once per tick
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        load counter from reload, clear prescaler, enter COUNT
//   stop         enter IDLE, counter frozen
//   autoreload   on expiry reload and keep counting (else go IDLE)
//   reload       reload value
//   expire       one-cycle pulse on the tick where the counter is zero
module irq_timer
   import nileswan_pkg::*;
#(
   parameter int PRESCALE = 384,
   parameter int TIMER_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               autoreload,
   input  logic [TIMER_W-1:0] reload,
   output logic               expire
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   timer_state_t       state;
   logic [PW-1:0]      presc;
   logic [TIMER_W-1:0] count;
   logic               tick;

   assign tick = (state == TMR_COUNT) && (presc == PRESC_LAST);

   // A control write in the same cycle wins over the tick, so no expiry
   // is reported for a count that is being restarted or stopped.
   assign expire = tick && (count == '0) && !start && !stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= TMR_IDLE;
         presc <= '0;
         count <= '0;
      end else if (start) begin
         state <= TMR_COUNT;
         presc <= '0;
         count <= reload;
      end else if (stop) begin
         state <= TMR_IDLE;
      end else if (state == TMR_COUNT) begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) begin
            if (count != '0)
               count <= count - TIMER_W'(1);
            else if (autoreload)
               count <= reload;
            else
               state <= TMR_IDLE;
         end
      end
   end

endmodule

// File: rtl/cart_irq_ctrl.sv
// Cartridge interrupt controller driving nCartInt to the console.
// Collects SPI transfer completion, a programmable timer and an MCU
// request, latches them in a write-1-to-clear status register and
// raises a level interrupt while any enabled status bit is pending.
//
// Build option: CART_IRQ_MCU_EN -- when defined the MCU source, its
// synchroniser and status/enable bit2 exist; otherwise nMCUIrq is ignored
// and bit2 reads 0.
//
// Ports:
//   FastClk, Reset      clock, synchronous active-high reset
//   RegWrEn             one-cycle register write strobe
//   RegAddr, RegWData   register address / write data
//   RegRData            combinational read data (0 outside 0xE6-0xEA)
//   RegAck              address is decoded by this block
//   SPIBusy             SPI engine busy level; falling edge = done
//   nMCUIrq             asynchronous active-low MCU request
//   nCartInt            registered active-low interrupt output
module cart_irq_ctrl
   import nileswan_pkg::*;
#(
   parameter int PRESCALE = 384,
   parameter int TIMER_W  = 16
) (
   input  logic       FastClk,
   input  logic       Reset,
   input  logic       RegWrEn,
   input  logic [7:0] RegAddr,
   input  logic [7:0] RegWData,
   output logic [7:0] RegRData,
   output logic       RegAck,
   input  logic       SPIBusy,
   input  logic       nMCUIrq,
   output logic       nCartInt
);

`ifdef CART_IRQ_MCU_EN
   localparam logic [IRQ_W-1:0] IRQ_MASK = 3'b111;
`else
   localparam logic [IRQ_W-1:0] IRQ_MASK = 3'b011;
`endif

   logic [IRQ_W-1:0] irq_en;
   logic [IRQ_W-1:0] irq_status;
   logic [7:0]       reload_lo;
   logic [7:0]       reload_hi;
   logic [1:0]       timer_ctrl;

   logic             wr_enable, wr_status, wr_lo, wr_hi, wr_ctrl;
   logic             spi_busy_q, spi_fall, mcu_fall, timer_expire;
   logic [IRQ_W-1:0] set_mask, clr_mask;

   assign wr_enable = RegWrEn && (RegAddr == IRQ_ENABLE);
   assign wr_status = RegWrEn && (RegAddr == IRQ_STATUS);
   assign wr_lo     = RegWrEn && (RegAddr == TIMER_RELOAD_LO);
   assign wr_hi     = RegWrEn && (RegAddr == TIMER_RELOAD_HI);
   assign wr_ctrl   = RegWrEn && (RegAddr == TIMER_CTRL);

   assign RegAck = (RegAddr >= IRQ_ENABLE) && (RegAddr <= TIMER_CTRL);

   always_comb begin
      RegRData = 8'h00;
      case (RegAddr)
         IRQ_ENABLE:      RegRData = {5'b0, irq_en};
         IRQ_STATUS:      RegRData = {5'b0, irq_status};
         TIMER_RELOAD_LO: RegRData = reload_lo;
         TIMER_RELOAD_HI: RegRData = reload_hi;
         TIMER_CTRL:      RegRData = {6'b0, timer_ctrl};
         default:         RegRData = 8'h00;
      endcase
   end

   assign spi_fall = spi_busy_q && !SPIBusy;

`ifdef CART_IRQ_MCU_EN
   logic mcu_sync1, mcu_sync2, mcu_prev;

   // Reset to the idle-high level so leaving reset never looks like a fall.
   always_ff @(posedge FastClk) begin
      if (Reset) begin
         mcu_sync1 <= 1'b1;
         mcu_sync2 <= 1'b1;
         mcu_prev  <= 1'b1;
      end else begin
         mcu_sync1 <= nMCUIrq;
         mcu_sync2 <= mcu_sync1;
         mcu_prev  <= mcu_sync2;
      end
   end

   assign mcu_fall = mcu_prev && !mcu_sync2;
`else
   logic unused_mcu;
   assign unused_mcu = nMCUIrq;
   assign mcu_fall   = 1'b0;
`endif

   irq_timer #(
      .PRESCALE (PRESCALE),
      .TIMER_W  (TIMER_W)
   ) u_timer (
      .clk        (FastClk),
      .rst        (Reset),
      .start      (wr_ctrl && RegWData[CTRL_BIT_RUN]),
      .stop       (wr_ctrl && !RegWData[CTRL_BIT_RUN]),
      .autoreload (timer_ctrl[CTRL_BIT_AUTO]),
      .reload     (TIMER_W'({reload_hi, reload_lo})),
      .expire     (timer_expire)
   );

   always_comb begin
      set_mask                = '0;
      set_mask[IRQ_BIT_SPI]   = spi_fall;
      set_mask[IRQ_BIT_TIMER] = timer_expire;
      set_mask[IRQ_BIT_MCU]   = mcu_fall;
      set_mask                = set_mask & IRQ_MASK;
      clr_mask                = wr_status ? (RegWData[IRQ_W-1:0] & IRQ_MASK) : '0;
   end

   always_ff @(posedge FastClk) begin
      if (Reset) begin
         irq_en     <= '0;
         irq_status <= '0;
         reload_lo  <= '0;
         reload_hi  <= '0;
         timer_ctrl <= '0;
         spi_busy_q <= 1'b0;
         nCartInt   <= 1'b1;
      end else begin
         spi_busy_q <= SPIBusy;
         if (wr_enable)
            irq_en <= RegWData[IRQ_W-1:0] & IRQ_MASK;
         // Set applied after clear: a simultaneous event keeps the bit.
         irq_status <= (irq_status & ~clr_mask) | set_mask;
         if (wr_lo)
            reload_lo <= RegWData;
         if (wr_hi)
            reload_hi <= RegWData;
         // One-shot expiry drops RUN so software can see the timer stopped.
         if (wr_ctrl)
            timer_ctrl <= RegWData[1:0];
         else if (timer_expire && !timer_ctrl[CTRL_BIT_AUTO])
            timer_ctrl[CTRL_BIT_RUN] <= 1'b0;
         nCartInt <= ~|(irq_status & irq_en);
      end
   end

endmodule

// File: tb/tb_cart_irq_ctrl.sv
module tb_cart_irq_ctrl;
   import nileswan_pkg::*;

   localparam int P = 4;
`ifdef CART_IRQ_MCU_EN
   localparam logic [2:0] MASK = 3'b111;
`else
   localparam logic [2:0] MASK = 3'b011;
`endif

   logic       FastClk = 1'b0;
   logic       Reset = 1'b1;
   logic       RegWrEn = 1'b0;
   logic [7:0] RegAddr = 8'h00;
   logic [7:0] RegWData = 8'h00;
   logic [7:0] RegRData;
   logic       RegAck;
   logic       SPIBusy = 1'b0;
   logic       nMCUIrq = 1'b1;
   logic       nCartInt;

   cart_irq_ctrl #(.PRESCALE(P), .TIMER_W(16)) dut (
      .FastClk  (FastClk),
      .Reset    (Reset),
      .RegWrEn  (RegWrEn),
      .RegAddr  (RegAddr),
      .RegWData (RegWData),
      .RegRData (RegRData),
      .RegAck   (RegAck),
      .SPIBusy  (SPIBusy),
      .nMCUIrq  (nMCUIrq),
      .nCartInt (nCartInt)
   );

   always #5 FastClk = ~FastClk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] rdata;
      logic       ack;
      logic       nint;
      longint     cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic chk = 1'b0;

   // Reference model: registers as software sees them, plus event bookkeeping.
   logic [2:0] m_en, m_stat;
   logic [7:0] m_lo, m_hi;
   logic [1:0] m_ctrl;
   logic       m_nint;
   longint     m_next_exp = 0;
   longint     ecount = 0;
   logic       h_busy;
   logic       h1, h2, h3;
   logic       cur_busy = 1'b0;
   logic       cur_mcu = 1'b1;

   function automatic longint period();
      return (longint'({m_hi, m_lo}) + 1) * P;
   endfunction

   function automatic logic [7:0] exp_rd(input logic [7:0] a);
      case (a)
         IRQ_ENABLE:      return {5'b0, m_en};
         IRQ_STATUS:      return {5'b0, m_stat};
         TIMER_RELOAD_LO: return m_lo;
         TIMER_RELOAD_HI: return m_hi;
         TIMER_CTRL:      return {6'b0, m_ctrl};
         default:         return 8'h00;
      endcase
   endfunction

   task automatic model_edge(input logic rst, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wd, input logic busy, input logic nmcu);
      logic [2:0] set_m;
      logic [2:0] clr_m;
      logic       ctrl_wr;
      ecount++;
      if (rst) begin
         m_en = '0; m_stat = '0; m_lo = '0; m_hi = '0; m_ctrl = '0;
         m_nint = 1'b1; h_busy = 1'b0; h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
         return;
      end
      m_nint = ~|(m_stat & m_en);
      set_m = '0;
      clr_m = '0;
      ctrl_wr = wr && (addr == TIMER_CTRL);
      if (h_busy && !busy) set_m[0] = 1'b1;
      // MCU level seen 3 and 2 edges ago: synchroniser plus edge register.
      if (h3 && !h2) set_m[2] = 1'b1;
      if (m_ctrl[0] && !ctrl_wr && ecount == m_next_exp) begin
         set_m[1] = 1'b1;
         if (m_ctrl[1]) m_next_exp = ecount + period();
         else m_ctrl[0] = 1'b0;
      end
      if (wr) begin
         case (addr)
            IRQ_ENABLE:      m_en = wd[2:0] & MASK;
            IRQ_STATUS:      clr_m = wd[2:0] & MASK;
            TIMER_RELOAD_LO: m_lo = wd;
            TIMER_RELOAD_HI: m_hi = wd;
            TIMER_CTRL: begin
               m_ctrl = wd[1:0];
               if (wd[0]) m_next_exp = ecount + period();
            end
            default: ;
         endcase
      end
      m_stat = ((m_stat & ~clr_m) | set_m) & MASK;
      h_busy = busy;
      h3 = h2; h2 = h1; h1 = nmcu;
   endtask

   task automatic cycle(input logic rst, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd);
      exp_t e;
      Reset = rst; RegWrEn = wr; RegAddr = addr; RegWData = wd;
      SPIBusy = cur_busy; nMCUIrq = cur_mcu;
      if (chk) begin
         e.addr = addr; e.rdata = exp_rd(addr);
         e.ack = (addr >= 8'hE6) && (addr <= 8'hEA);
         e.nint = m_nint; e.cyc = ecount;
         sb_q.push_back(e);
      end
      @(posedge FastClk);
      model_edge(rst, wr, addr, wd, cur_busy, cur_mcu);
      #1;
   endtask

   task automatic rd(input logic [7:0] a, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a, 8'h00);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      cycle(1'b0, 1'b1, a, d);
   endtask

   always @(negedge FastClk) begin
      if (chk) begin
         if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty at t=%0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (RegRData !== e.rdata) begin
               n_fail++;
               $display("FAIL rdata addr=%h edge=%0d got=%h exp=%h", e.addr, e.cyc, RegRData, e.rdata);
            end
            n_checks++;
            if (RegAck !== e.ack) begin
               n_fail++;
               $display("FAIL ack addr=%h edge=%0d got=%b exp=%b", e.addr, e.cyc, RegAck, e.ack);
            end
            n_checks++;
            if (nCartInt !== e.nint) begin
               n_fail++;
               $display("FAIL nCartInt edge=%0d got=%b exp=%b", e.cyc, nCartInt, e.nint);
            end
         end
      end
   end

   initial begin
      logic [7:0] a, d;
      int r;

      #1;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00);
      chk = 1'b1;

      // reset values and decode window
      rd(8'hE5, 1); rd(8'hE6, 1); rd(8'hE7, 1); rd(8'hE8, 1);
      rd(8'hE9, 1); rd(8'hEA, 1); rd(8'hEB, 1); rd(8'h00, 1);

      // SPI done source with W1C
      wr(IRQ_ENABLE, 8'h01);
      cur_busy = 1'b1; rd(IRQ_STATUS, 10);
      cur_busy = 1'b0; rd(IRQ_STATUS, 4);
      wr(IRQ_STATUS, 8'h01);
      rd(IRQ_STATUS, 3);

      // autoreload timer with continuous W1C: set must win on each expiry
      wr(TIMER_RELOAD_LO, 8'h02); wr(TIMER_RELOAD_HI, 8'h00);
      wr(IRQ_ENABLE, 8'h02);
      wr(TIMER_CTRL, 8'h03);
      for (int i = 0; i < 40; i++) wr(IRQ_STATUS, 8'h02);

      // one-shot: RUN drops after the single expiry
      wr(TIMER_CTRL, 8'h01);
      rd(TIMER_CTRL, 16);
      rd(IRQ_STATUS, 2);
      wr(IRQ_STATUS, 8'h07);

      // MCU request (ignored when the source is not built)
      wr(IRQ_ENABLE, 8'h04);
      cur_mcu = 1'b0; rd(IRQ_STATUS, 8);
      cur_mcu = 1'b1; rd(IRQ_ENABLE, 2);
      wr(IRQ_STATUS, 8'h04); rd(IRQ_STATUS, 2);

      // enabling an already pending bit
      cur_busy = 1'b1; rd(IRQ_STATUS, 2); cur_busy = 1'b0; rd(IRQ_STATUS, 3);
      wr(IRQ_ENABLE, 8'h01); rd(IRQ_STATUS, 3);

      // reset mid-count with status pending
      wr(IRQ_ENABLE, 8'h03); wr(TIMER_CTRL, 8'h03);
      rd(IRQ_STATUS, 5);
      cycle(1'b1, 1'b0, IRQ_STATUS, 8'h00);
      for (int i = 0; i < 30; i++) rd(8'(8'hE6 + (i % 5)), 1);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) cur_busy = ~cur_busy;
         if ($urandom_range(0, 9) == 0) cur_mcu = ~cur_mcu;
         r = $urandom_range(0, 15);
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 599) == 0) begin
            cycle(1'b1, 1'b0, IRQ_STATUS, 8'h00);
         end else if (r == 0) wr(IRQ_ENABLE, d);
         else if (r == 1) wr(IRQ_STATUS, d);
         else if (r == 2) wr(TIMER_RELOAD_LO, 8'($urandom_range(0, 6)));
         else if (r == 3) wr(TIMER_RELOAD_HI, ($urandom_range(0, 9) == 0) ? d : 8'h00);
         else if (r == 4 && $urandom_range(0, 3) == 0) wr(TIMER_CTRL, d);
         else begin
            a = 8'($urandom_range(8'hE4, 8'hEC));
            rd(a, 1);
         end
      end

      rd(IRQ_STATUS, 2);
      chk = 1'b0;
      @(negedge FastClk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
